// File: rtl/tag_free_list.sv
// Free list of rename/reservation tags: allocate at dispatch, release out of order
// at retirement, and rewind the allocation pointer to a branch checkpoint on mispredict.
module tag_free_list #(
  parameter int TAG_W    = 5,
  parameter int NUM_CKPT = 4,
  parameter int CKPT_W   = 2
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              flush_valid,
  input  logic              alloc_en,
  output logic [TAG_W-1:0]  tag_out,
  output logic              alloc_valid,
  input  logic              release_en,
  input  logic [TAG_W-1:0]  release_tag,
  input  logic              ckpt_en,
  input  logic [CKPT_W-1:0] ckpt_id,
  input  logic              restore_en,
  input  logic [CKPT_W-1:0] restore_id,
  output logic [TAG_W:0]    free_count,
  output logic              all_free,
  output logic              err
);

  localparam int DEPTH = 1 << TAG_W;
  localparam logic [TAG_W:0] DEPTH_PTR = (TAG_W+1)'(DEPTH);

  logic [TAG_W-1:0] mem  [DEPTH];
  logic [TAG_W:0]   ckpt [NUM_CKPT];
  logic [TAG_W:0]   rp;
  logic [TAG_W:0]   wp;
  logic             err_q;

  logic             do_alloc;
  logic             do_release;
  logic             alloc_under;
  logic             release_over;
  logic [TAG_W:0]   rp_next_alloc;

  assign free_count  = wp - rp;
  assign alloc_valid = (free_count != '0);
  assign all_free    = (free_count == DEPTH_PTR);
  assign tag_out     = mem[rp[TAG_W-1:0]];
  assign err         = err_q;

  // A restore owns the read pointer for the cycle, so allocation is suppressed then.
  assign do_alloc      = alloc_en && alloc_valid && !restore_en;
  assign do_release    = release_en && !all_free;
  assign alloc_under   = alloc_en && !alloc_valid && !restore_en;
  assign release_over  = release_en && all_free;
  assign rp_next_alloc = do_alloc ? rp + 1'b1 : rp;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      rp    <= '0;
      wp    <= DEPTH_PTR;
      err_q <= 1'b0;
    end else if (flush_valid) begin
      rp    <= '0;
      wp    <= DEPTH_PTR;
      err_q <= 1'b0;
    end else begin
      if (restore_en) begin
        rp <= ckpt[restore_id];
      end else begin
        rp <= rp_next_alloc;
      end
      if (do_release) begin
        wp <= wp + 1'b1;
      end
      if (alloc_under || release_over) begin
        err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= TAG_W'(i);
    end else if (flush_valid) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= TAG_W'(i);
    end else if (do_release) begin
      mem[wp[TAG_W-1:0]] <= release_tag;
    end
  end

  // The checkpoint captures rp after this cycle's allocation, so the branch's own tag survives a restore.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < NUM_CKPT; i++) ckpt[i] <= '0;
    end else if (flush_valid) begin
      for (int i = 0; i < NUM_CKPT; i++) ckpt[i] <= '0;
    end else if (ckpt_en && !restore_en) begin
      ckpt[ckpt_id] <= rp_next_alloc;
    end
  end

endmodule

// File: tb/tb_tag_free_list.sv
// Randomised and directed bench for tag_free_list against a queue-based model of the
// tag stream (every tag ever made free, in order) and an absolute allocation count.
module tb_tag_free_list;

  localparam int TAG_W    = 5;
  localparam int NUM_CKPT = 4;
  localparam int CKPT_W   = 2;
  localparam int DEPTH    = 32;

  logic              clock = 1'b0;
  logic              nreset = 1'b0;
  logic              flush_valid = 1'b0;
  logic              alloc_en = 1'b0;
  logic              release_en = 1'b0;
  logic              ckpt_en = 1'b0;
  logic              restore_en = 1'b0;
  logic [TAG_W-1:0]  release_tag = '0;
  logic [CKPT_W-1:0] ckpt_id = '0;
  logic [CKPT_W-1:0] restore_id = '0;
  logic [TAG_W-1:0]  tag_out;
  logic              alloc_valid;
  logic              all_free;
  logic              err;
  logic [TAG_W:0]    free_count;

  int total = 0;
  int bad   = 0;

  // Model: seq holds every tag made free since reset/flush, in order; na counts allocations.
  int seq[$];
  int na;
  int ck[NUM_CKPT];
  bit merr;
  int outt[$];
  int outi[$];

  tag_free_list #(.TAG_W(TAG_W), .NUM_CKPT(NUM_CKPT), .CKPT_W(CKPT_W)) dut (
    .clock(clock), .nreset(nreset), .flush_valid(flush_valid),
    .alloc_en(alloc_en), .tag_out(tag_out), .alloc_valid(alloc_valid),
    .release_en(release_en), .release_tag(release_tag),
    .ckpt_en(ckpt_en), .ckpt_id(ckpt_id),
    .restore_en(restore_en), .restore_id(restore_id),
    .free_count(free_count), .all_free(all_free), .err(err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mfree();
    return seq.size() - na;
  endfunction

  function automatic void model_reset();
    seq.delete();
    for (int i = 0; i < DEPTH; i++) seq.push_back(i);
    na = 0;
    for (int i = 0; i < NUM_CKPT; i++) ck[i] = 0;
    merr = 1'b0;
    outt.delete();
    outi.delete();
  endfunction

  function automatic void model_update();
    bit av, af, a_ok, r_ok;
    int c;
    if (flush_valid) begin
      model_reset();
      return;
    end
    av   = (mfree() != 0);
    af   = (mfree() == DEPTH);
    a_ok = alloc_en && av && !restore_en;
    r_ok = release_en && !af;
    if ((alloc_en && !av && !restore_en) || (release_en && af)) merr = 1'b1;
    if (a_ok) begin
      outt.push_back(seq[na]);
      outi.push_back(na);
    end
    if (restore_en) begin
      c  = ck[restore_id];
      na = c;
      while (outi.size() > 0 && outi[outi.size()-1] >= c) begin
        void'(outi.pop_back());
        void'(outt.pop_back());
      end
    end else begin
      if (ckpt_en) ck[ckpt_id] = na + (a_ok ? 1 : 0);
      if (a_ok) na++;
    end
    if (r_ok) seq.push_back(int'(release_tag));
  endfunction

  task automatic check_outputs();
    check("free_count", 32'(free_count), 32'(mfree()));
    check("alloc_valid", 32'(alloc_valid), 32'(mfree() != 0));
    check("all_free", 32'(all_free), 32'(mfree() == DEPTH));
    check("err", 32'(err), 32'(merr));
    if (mfree() != 0) check("tag_out", 32'(tag_out), 32'(seq[na]));
  endtask

  task automatic step();
    @(negedge clock);
    check_outputs();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic idle();
    flush_valid = 1'b0;
    alloc_en    = 1'b0;
    release_en  = 1'b0;
    ckpt_en     = 1'b0;
    restore_en  = 1'b0;
  endtask

  task automatic take_out(output logic [TAG_W-1:0] t);
    int k;
    k = $urandom_range(0, outt.size() - 1);
    t = TAG_W'(outt[k]);
    outt.delete(k);
    outi.delete(k);
  endtask

  initial begin
    int order[3];
    logic [31:0] mask;
    int id;
    bit r;

    model_reset();
    #12;
    check("rst_tag", 32'(tag_out), 0);
    check("rst_valid", 32'(alloc_valid), 1);
    check("rst_free", 32'(free_count), 32);
    check("rst_all_free", 32'(all_free), 1);
    check("rst_err", 32'(err), 0);
    @(posedge clock);
    #1 nreset = 1'b1;

    // Drain all tags in order, then underflow.
    alloc_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("alloc_seq", 32'(tag_out), 32'(i));
      step();
    end
    idle();
    check("empty_free", 32'(free_count), 0);
    check("empty_valid", 32'(alloc_valid), 0);
    alloc_en = 1'b1;
    step();
    idle();
    check("underflow_err", 32'(err), 1);
    check("underflow_free", 32'(free_count), 0);

    // Out-of-order release comes back in release order.
    order = '{7, 3, 19};
    release_en = 1'b1;
    foreach (order[i]) begin
      release_tag = TAG_W'(order[i]);
      step();
    end
    idle();
    alloc_en = 1'b1;
    foreach (order[i]) begin
      check("realloc", 32'(tag_out), 32'(order[i]));
      step();
    end
    idle();
    release_en  = 1'b1;
    release_tag = 5'd5;
    check("no_bypass", 32'(alloc_valid), 0);
    step();
    release_tag = 5'd9;
    alloc_en    = 1'b1;
    check("pre_swap_tag", 32'(tag_out), 5);
    step();
    idle();
    check("swap_free", 32'(free_count), 1);
    check("swap_tag", 32'(tag_out), 9);

    // Checkpoint taken together with the branch's allocation, then restore.
    flush_valid = 1'b1;
    step();
    idle();
    check("flush_err", 32'(err), 0);
    alloc_en = 1'b1;
    repeat (4) step();
    ckpt_en = 1'b1;
    ckpt_id = 2'd2;
    step();
    ckpt_en = 1'b0;
    repeat (5) step();
    idle();
    restore_en = 1'b1;
    restore_id = 2'd2;
    step();
    idle();
    check("restore_tag", 32'(tag_out), 5);
    check("restore_free", 32'(free_count), 27);

    // Restore beats alloc and ckpt; a concurrent release still lands.
    restore_en  = 1'b1;
    restore_id  = 2'd2;
    release_en  = 1'b1;
    release_tag = 5'd2;
    alloc_en    = 1'b1;
    step();
    idle();
    check("rst_rel_free", 32'(free_count), 28);
    check("rst_rel_tag", 32'(tag_out), 5);
    alloc_en = 1'b1;
    repeat (3) step();
    restore_en = 1'b1;
    ckpt_en    = 1'b1;
    ckpt_id    = 2'd2;
    step();
    idle();
    alloc_en = 1'b1;
    repeat (2) step();
    idle();
    restore_en = 1'b1;
    step();
    idle();
    check("ckpt_kept_tag", 32'(tag_out), 5);
    check("ckpt_kept_free", 32'(free_count), 28);

    // Overflow while all free, then flush clears it.
    flush_valid = 1'b1;
    step();
    idle();
    release_en  = 1'b1;
    release_tag = 5'd4;
    step();
    idle();
    check("overflow_err", 32'(err), 1);
    check("overflow_free", 32'(free_count), 32);
    flush_valid = 1'b1;
    step();
    idle();
    check("flush2_err", 32'(err), 0);
    check("flush2_tag", 32'(tag_out), 0);
    check("flush2_free", 32'(free_count), 32);

    // Random alloc/release streams across many wraps.
    repeat (400) begin
      alloc_en = ($urandom_range(0, 99) < 55);
      if (outt.size() > 0 && $urandom_range(0, 99) < 50) begin
        release_en = 1'b1;
        take_out(release_tag);
      end
      step();
      idle();
    end
    while (outt.size() > 0) begin
      release_en  = 1'b1;
      release_tag = TAG_W'(outt.pop_front());
      void'(outi.pop_front());
      step();
    end
    idle();
    check("drain_free", 32'(free_count), 32);
    mask = '0;
    alloc_en = 1'b1;
    repeat (DEPTH) begin
      mask = mask | (32'd1 << tag_out);
      step();
    end
    idle();
    check("conserve", mask, 32'hFFFF_FFFF);

    // Random stream including checkpoints and restores.
    flush_valid = 1'b1;
    step();
    idle();
    repeat (400) begin
      alloc_en = ($urandom_range(0, 99) < 50);
      r = (outt.size() > 0 && $urandom_range(0, 99) < 45);
      if (r) begin
        release_en = 1'b1;
        take_out(release_tag);
      end
      if ($urandom_range(0, 99) < 20) begin
        ckpt_en = 1'b1;
        ckpt_id = CKPT_W'($urandom_range(0, NUM_CKPT - 1));
      end
      id = $urandom_range(0, NUM_CKPT - 1);
      if ($urandom_range(0, 99) < 10 && ck[id] <= na &&
          (seq.size() + (r ? 1 : 0) - ck[id]) <= DEPTH) begin
        restore_en = 1'b1;
        restore_id = CKPT_W'(id);
      end
      step();
      idle();
    end

    // Asynchronous reset in the middle of traffic.
    alloc_en = 1'b1;
    repeat (5) step();
    #2 nreset = 1'b0;
    #1;
    check("async_tag", 32'(tag_out), 0);
    check("async_valid", 32'(alloc_valid), 1);
    check("async_free", 32'(free_count), 32);
    check("async_all_free", 32'(all_free), 1);
    check("async_err", 32'(err), 0);
    idle();
    model_reset();
    @(negedge clock);
    nreset = 1'b1;
    @(posedge clock);
    #1;
    alloc_en = 1'b1;
    repeat (3) step();
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tag_free_list.md
# tag_free_list

Parametrised free-list of rename/reservation tags for the out-of-order core, replacing the fixed 32-entry tag FIFO. It hands out free tags at dispatch and takes tags back at retirement in arbitrary order. It supports branch checkpoints, so a mispredict returns only the tags allocated after the branch, without a full flush. It sits between dispatch (allocation), the retirement/commit logic (release) and the branch unit (checkpoint/restore).

## Interface
- TAG_W, 5: tag width; DEPTH = 2**TAG_W tags, all free after reset.
- NUM_CKPT, 4: number of checkpoint slots.
- CKPT_W, 2: checkpoint index width, clog2(NUM_CKPT).

Ports:
- clock  in  1  single clock, rising edge.
- nreset  in  1  asynchronous, active-low reset.
- flush_valid  in  1  synchronous full flush: every tag becomes free.
- alloc_en  in  1  consume the tag on tag_out.
- tag_out  out  TAG_W  next free tag (combinational from storage at read pointer).
- alloc_valid  out  1  at least one free tag; tag_out is meaningful.
- release_en  in  1  return release_tag to the list.
- release_tag  in  TAG_W  tag being returned.
- ckpt_en  in  1  save the allocation pointer into slot ckpt_id.
- ckpt_id  in  CKPT_W  checkpoint slot to write.
- restore_en  in  1  rewind the allocation pointer to slot restore_id.
- restore_id  in  CKPT_W  checkpoint slot to restore.
- free_count  out  TAG_W+1  number of free tags, 0..DEPTH.
- all_free  out  1  free_count == DEPTH.
- err  out  1  sticky error flag (underflow/overflow); cleared only by reset or flush.

## Operation
- Storage: DEPTH x TAG_W register array. Pointers rp (allocate) and wp (release) are TAG_W+1 bits wide; the MSB is the wrap bit.
- Reset/flush state:
  - mem[i] = i for every i.
  - rp = 0; wp = DEPTH (wrap bit set, index 0).
  - All checkpoint slots = 0.
  - err = 0.
- Derived values:
  - free_count = wp - rp, modulo 2**(TAG_W+1).
  - alloc_valid = (free_count != 0).
  - all_free = (free_count == DEPTH).
  - tag_out = mem[rp[TAG_W-1:0]].
- Allocate: alloc_en && alloc_valid increments rp.
  - alloc_en && !alloc_valid: no change, err set.
- Release: release_en && !all_free writes mem[wp index] = release_tag and increments wp.
  - release_en && all_free: ignored, err set.
  - Tag contents are not checked for duplicates.
- Checkpoint: ckpt_en stores the post-allocation rp for this cycle into slot ckpt_id. That value is rp+1 if an allocation occurs in the same cycle, otherwise rp. The tag allocated alongside the branch therefore survives a restore.
- Restore: restore_en sets rp = ckpt[restore_id].
  - Any alloc_en and ckpt_en in the same cycle are ignored.
  - A release in the same cycle still completes.
- Priority: reset > flush_valid > restore_en > (alloc, ckpt, release).
  - Alloc, ckpt and release are independent and may all occur in one cycle.
- Restore correctness rests on the core retiring in order: tags younger than an unresolved branch are never released before it resolves. The block does not check this.
- Pointer wrap is natural modulo-2**(TAG_W+1) arithmetic. There is no special case at index DEPTH-1 -> 0.

## Timing
- All state updates happen on the rising clock edge. Reset acts immediately on the nreset falling edge.
- tag_out, alloc_valid, free_count and all_free are combinational from registers: valid in the same cycle as alloc_en, with no input-to-output combinational path.
- A released tag becomes allocatable from the cycle after release.
  - There is no same-cycle bypass: with free_count == 0 and release_en high, alloc_valid stays 0 that cycle.
- Simultaneous alloc + release: free_count is unchanged next cycle.
- A restore takes effect next cycle: free_count = wp' - ckpt value.
- Reset asserted mid-operation: all outputs return to reset values asynchronously.
  - tag_out = 0, alloc_valid = 1, free_count = DEPTH, all_free = 1, err = 0.

## Test plan
- Reset then 32 back-to-back allocs (TAG_W=5) -> tag_out = 0,1,...,31; free_count 32 -> 0; alloc_valid drops after the 32nd; a 33rd alloc sets err = 1 and rp does not move.
- Drain fully, release 7, 3, 19, then allocate 3 -> tags 7, 3, 19 in order. Release and alloc in the same cycle at free_count = 1 -> free_count stays 1.
- Allocate 4 (tags 0-3); ckpt_en with alloc_en on tag 4 into slot 2; allocate 5-9; restore slot 2 -> next tag_out = 5, free_count = 27.
- Restore with simultaneous release of tag 2 and alloc_en -> rp = checkpoint, wp advances by 1, allocation ignored. Restore and ckpt together -> slot unchanged.
- Release while all_free -> err = 1, free_count stays 32. Then flush_valid -> err = 0, tag_out = 0, free_count = 32.
- Wrap: run alloc/release streams for more than 3*DEPTH cycles with random release order -> free_count always equals the model count, and the multiset of tags is conserved. Assert nreset mid-stream -> immediate reset values.
